// File: rtl/calc_btn_pkg.sv
// -----------------------------------------------------------------------------
// calc_btn_pkg
//   Shared types and constants for the calculator pushbutton conditioner.
//   - btn_state_t : per-button debounce FSM state
//   - BTN_*       : index of each button in the internal button vectors
//   - is_down()   : true in the states where the accepted (stable) level is 1
// -----------------------------------------------------------------------------
package calc_btn_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int BTN_C   = 0;
  localparam int BTN_L   = 1;
  localparam int BTN_U   = 2;
  localparam int BTN_R   = 3;
  localparam int BTN_D   = 4;
  localparam int NUM_BTN = 5;

  // A WAIT state still reports the level it is waiting to leave.
  function automatic logic is_down(btn_state_t st);
    return (st == PRESSED) || (st == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/calc_btn_if.sv
// -----------------------------------------------------------------------------
// calc_btn_if
//   Raw button pins in, conditioned buttons out.
//   modport master : board / test side, drives *_i, observes *_o
//   modport slave  : calc_btn_cond, consumes *_i, drives *_o
//   btnc/btnl/btnr_o are debounced levels; btnu/btnd_o are one-cycle pulses.
// -----------------------------------------------------------------------------
interface calc_btn_if;
  logic btnc_i, btnl_i, btnr_i, btnu_i, btnd_i;
  logic btnc_o, btnl_o, btnr_o, btnu_o, btnd_o;

  modport master (
    output btnc_i, btnl_i, btnr_i, btnu_i, btnd_i,
    input  btnc_o, btnl_o, btnr_o, btnu_o, btnd_o
  );

  modport slave (
    input  btnc_i, btnl_i, btnr_i, btnu_i, btnd_i,
    output btnc_o, btnl_o, btnr_o, btnu_o, btnd_o
  );
endinterface

// File: rtl/calc_btn_debounce.sv
// -----------------------------------------------------------------------------
// calc_btn_debounce
//   One button: 2-flop synchroniser, debounce counter/FSM, rise pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   pin_i      : raw asynchronous button pin
//   level_o    : accepted stable level
//   rise_o     : registered one-cycle pulse on the edge the level goes 0->1
// -----------------------------------------------------------------------------
module calc_btn_debounce
  import calc_btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source; the synchroniser only works that way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= RELEASED;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  // The counter runs only while sync2 disagrees with the accepted level and
  // restarts from 0 whenever they agree, so a glitch never accumulates.
  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a variable
    // unassigned and infers a latch.
    state_d = state_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (sync2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!sync2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (sync2_q) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  assign level_o = is_down(state_q);
  assign rise_o  = rise_q;

endmodule

// File: rtl/calc_btn_cond.sv
// -----------------------------------------------------------------------------
// calc_btn_cond
//   Conditions the five calculator pushbuttons.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn        : calc_btn_if.slave
//                btnc/btnl/btnr_o -> debounced levels (op-select code)
//                btnu/btnd_o      -> one-cycle press pulses (clear / load)
//   Optional macro CALC_BTN_AUTOREPEAT_EN: while btnd stays down, extra btnd_o
//   pulses REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD.
// -----------------------------------------------------------------------------
module calc_btn_cond
  import calc_btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic          clk,
  input  logic          rst_n,
  calc_btn_if.slave     btn
);

  logic [NUM_BTN-1:0] pin, level, rise;

  assign pin[BTN_C] = btn.btnc_i;
  assign pin[BTN_L] = btn.btnl_i;
  assign pin[BTN_U] = btn.btnu_i;
  assign pin[BTN_R] = btn.btnr_i;
  assign pin[BTN_D] = btn.btnd_i;

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    calc_btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .pin_i   (pin[b]),
      .level_o (level[b]),
      .rise_o  (rise[b])
    );
  end

  assign btn.btnc_o = level[BTN_C];
  assign btn.btnl_o = level[BTN_L];
  assign btn.btnr_o = level[BTN_R];
  assign btn.btnu_o = rise[BTN_U];

`ifdef CALC_BTN_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             in_period_q, in_period_d;  // 0: waiting out REPEAT_DELAY
  logic             rep_pulse_q, rep_pulse_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q   <= '0;
      in_period_q <= 1'b0;
      rep_pulse_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      in_period_q <= in_period_d;
      rep_pulse_q <= rep_pulse_d;
    end
  end

  // The timer is held at 0 while btnd is up, so it starts counting on the
  // cycle the press pulse is visible and each pulse lands on count == limit-1.
  always_comb begin
    rep_cnt_d   = '0;
    in_period_d = 1'b0;
    rep_pulse_d = 1'b0;
    if (level[BTN_D]) begin
      in_period_d = in_period_q;
      if (rep_cnt_q == (in_period_q ? REP_W'(REPEAT_PERIOD - 1)
                                    : REP_W'(REPEAT_DELAY - 1))) begin
        rep_pulse_d = 1'b1;
        in_period_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end

  assign btn.btnd_o = rise[BTN_D] | rep_pulse_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, level[BTN_U], rise[BTN_C], rise[BTN_L], rise[BTN_R]};
`else
  assign btn.btnd_o = rise[BTN_D];

  logic unused_ok;
  assign unused_ok = &{1'b0, level[BTN_U], level[BTN_D], rise[BTN_C],
                       rise[BTN_L], rise[BTN_R], (REPEAT_DELAY > 0),
                       (REPEAT_PERIOD > 0)};
`endif

endmodule

// File: tb/tb_calc_btn_cond.sv
// -----------------------------------------------------------------------------
// tb_calc_btn_cond
//   Directed bench for calc_btn_cond with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8,
//   REPEAT_PERIOD=3. Each scenario drives pins for a number of edges and
//   records every output after each edge into a bitmask (bit i = edge i,
//   counted from the first edge after the stimulus starts); the masks are
//   compared with hand-derived expectations. A pin held from edge 1 is
//   accepted at edge N+2 = 6.
// -----------------------------------------------------------------------------
module tb_calc_btn_cond;
  import calc_btn_pkg::*;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic clk;
  logic rst_n;
  logic [NUM_BTN-1:0] pins;
  logic [NUM_BTN-1:0] outv;
  logic [63:0]        hits [NUM_BTN];

  int checks = 0;
  int errors = 0;

  calc_btn_if bif ();

  calc_btn_cond #(
    .DEBOUNCE_CYCLES (N),
    .CNT_W           ($clog2(N + 1)),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bif)
  );

  assign bif.btnc_i = pins[BTN_C];
  assign bif.btnl_i = pins[BTN_L];
  assign bif.btnu_i = pins[BTN_U];
  assign bif.btnr_i = pins[BTN_R];
  assign bif.btnd_i = pins[BTN_D];

  assign outv[BTN_C] = bif.btnc_o;
  assign outv[BTN_L] = bif.btnl_o;
  assign outv[BTN_U] = bif.btnu_o;
  assign outv[BTN_R] = bif.btnr_o;
  assign outv[BTN_D] = bif.btnd_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bits 1..n set.
  function automatic logic [63:0] ones(input int n);
    return (64'd1 << (n + 1)) - 64'd2;
  endfunction

  // Drive pins selected by 'which' with pat[i] before edge i, for n edges,
  // sampling all outputs 1 time unit after each edge.
  task automatic apply(input logic [NUM_BTN-1:0] which, input logic [63:0] pat,
                       input int n);
    for (int b = 0; b < NUM_BTN; b++) hits[b] = '0;
    for (int i = 1; i <= n; i++) begin
      for (int b = 0; b < NUM_BTN; b++)
        if (which[b]) pins[b] = pat[i];
      @(posedge clk);
      #1;
      for (int b = 0; b < NUM_BTN; b++) hits[b][i] = outv[b];
    end
  endtask

  // Asynchronous reset asserted mid-cycle for one edge; outputs must clear at
  // once. The first edge after return is edge 1 of the next apply().
  task automatic mid_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check(tag, 64'(outv), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  localparam logic [NUM_BTN-1:0] ALL = '1;
  localparam logic [NUM_BTN-1:0] M_C = NUM_BTN'(1 << BTN_C);
  localparam logic [NUM_BTN-1:0] M_L = NUM_BTN'(1 << BTN_L);
  localparam logic [NUM_BTN-1:0] M_U = NUM_BTN'(1 << BTN_U);
  localparam logic [NUM_BTN-1:0] M_R = NUM_BTN'(1 << BTN_R);
  localparam logic [NUM_BTN-1:0] M_D = NUM_BTN'(1 << BTN_D);

  initial begin
    rst_n = 1'b0;
    pins  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 64'(outv), 64'd0);
    rst_n = 1'b1;

    // All pins pressed: levels at edge 6, one pulse each at edge 6.
    apply(ALL, ones(8), 8);
    check("all_press_c", hits[BTN_C], 64'h1C0);
    check("all_press_u", hits[BTN_U], 64'h040);

    // Reset with pins high, then held through release: treated as new press.
    mid_reset("rst_pins_high");
    apply(ALL, ones(10), 10);
    check("rst_rel_c", hits[BTN_C], 64'h7C0);
    check("rst_rel_l", hits[BTN_L], 64'h7C0);
    check("rst_rel_r", hits[BTN_R], 64'h7C0);
    check("rst_rel_u", hits[BTN_U], 64'h040);
    check("rst_rel_d", hits[BTN_D], 64'h040);

    // Release all: levels fall at edge 6, no pulse on release.
    apply(ALL, 64'd0, 10);
    check("rel_c", hits[BTN_C], 64'h03E);
    check("rel_u", hits[BTN_U], 64'd0);

    // 3-cycle glitch on a released button is discarded.
    apply(M_C, 64'h00E, 12);
    check("glitch_c", hits[BTN_C], 64'd0);

    // Bounce 1,1,1,0,1,... : last 0 at edge 4, clean 1 from edge 5 -> edge 10.
    apply(M_L, 64'h7FEE, 14);
    check("bounce_l", hits[BTN_L], 64'h7C00);
    apply(M_L, 64'd0, 10);
    check("bounce_l_rel", hits[BTN_L], 64'h03E);

    // Clean btnd press held 30 cycles, then released.
    apply(M_D, ones(30), 30);
`ifdef CALC_BTN_AUTOREPEAT_EN
    check("btnd_hold_rep", hits[BTN_D], 64'h24924040);
    // Level stays 1 until release edge 6, so the timer still fires at
    // absolute edges 32 and 35 (release edges 2 and 5), then stops.
    apply(M_D, 64'd0, 12);
    check("btnd_rel_rep", hits[BTN_D], 64'h024);
`else
    check("btnd_hold", hits[BTN_D], 64'h040);
    apply(M_D, 64'd0, 12);
    check("btnd_rel", hits[BTN_D], 64'd0);
`endif

    // btnr held, then btnu and btnd together: coincident pulses, btnr steady.
    apply(M_R, ones(8), 8);
    check("r_press", hits[BTN_R], 64'h1C0);
    apply(M_U | M_D, ones(10), 10);
    check("simul_u", hits[BTN_U], 64'h040);
    check("simul_d", hits[BTN_D], 64'h040);
    check("simul_r", hits[BTN_R], 64'h7FE);
    apply(ALL, 64'd0, 10);
    check("simul_rel_u", hits[BTN_U], 64'd0);
    check("simul_rel_r", hits[BTN_R], 64'h03E);

    // btnu reaches cnt=2 after 4 edges; reset discards it entirely.
    apply(M_U, ones(4), 4);
    check("u_pre_rst", hits[BTN_U], 64'd0);
    mid_reset("rst_mid_debounce");
    apply(M_U, ones(10), 10);
    check("u_after_rst", hits[BTN_U], 64'h040);
    apply(M_U, 64'd0, 10);
    check("u_rel", hits[BTN_U], 64'd0);
    check("final_idle", 64'(outv), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
